angle_to_sw: RTL and testbench

ANGLE_TO_SW -- requirements
Module: angle_to_sw

---
 rtl/angle_pkg.sv | 13 +
 rtl/angle_to_sw.sv | 99 +++++++++
 tb/tb_angle_to_sw.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/angle_pkg.sv
// rtl/angle_pkg.sv - shared constants and FSM state encoding for the angle-to-switch converter
package angle_pkg;

    localparam int STEP      = 24;
    localparam int NUM_POS   = 16;
    localparam int MAX_ANGLE = STEP * (NUM_POS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } state_t;

endpackage

// File: rtl/angle_to_sw.sv
// rtl/angle_to_sw.sv - converts an angle to a one-hot switch position by repeated subtraction
// Optional build macro ANGLE_ROUND_EN: round the position half up instead of truncating.
import angle_pkg::*;

module angle_to_sw #(
    parameter int STEP    = angle_pkg::STEP,
    parameter int NUM_POS = angle_pkg::NUM_POS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8:0]         angle_in,
    input  logic               angle_valid,
    output logic               angle_ready,
    output logic [NUM_POS-1:0] sw_onehot,
    output logic               sw_valid,
    output logic               exact,
    output logic               range_err
);

    localparam int                 IDX_W  = $clog2(NUM_POS);
    localparam logic [8:0]         STEP_W = 9'(STEP);
    localparam logic [8:0]         MAX_W  = 9'(STEP * (NUM_POS - 1));
    localparam logic [NUM_POS-1:0] ONE    = NUM_POS'(1);
`ifdef ANGLE_ROUND_EN
    localparam logic [8:0]         HALF_W = 9'(STEP / 2);
`endif

    state_t               state, state_next;
    logic [8:0]           rem, rem_next;
    logic [IDX_W-1:0]     idx, idx_next, idx_fin;
    logic [NUM_POS-1:0]   onehot_next;
    logic                 valid_next, exact_next, err_next;

    assign angle_ready = (state == IDLE);

    always_comb begin
        state_next  = state;
        rem_next    = rem;
        idx_next    = idx;
        idx_fin     = idx;
        onehot_next = sw_onehot;
        exact_next  = exact;
        err_next    = range_err;
        valid_next  = 1'b0;
        case (state)
            IDLE: begin
                if (angle_valid) begin
                    if (angle_in > MAX_W) begin
                        // Out-of-range angles are answered immediately without dividing
                        onehot_next = '0;
                        exact_next  = 1'b0;
                        err_next    = 1'b1;
                        valid_next  = 1'b1;
                    end else begin
                        rem_next   = angle_in;
                        idx_next   = '0;
                        state_next = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (rem >= STEP_W) begin
                    rem_next = rem - STEP_W;
                    idx_next = idx + IDX_W'(1);
                end else begin
`ifdef ANGLE_ROUND_EN
                    if (rem >= HALF_W) idx_fin = idx + IDX_W'(1);
`endif
                    onehot_next = ONE << idx_fin;
                    exact_next  = (rem == 9'd0);
                    err_next    = 1'b0;
                    valid_next  = 1'b1;
                    state_next  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            idx       <= '0;
            sw_onehot <= ONE;
            sw_valid  <= 1'b0;
            exact     <= 1'b1;
            range_err <= 1'b0;
        end else begin
            state     <= state_next;
            rem       <= rem_next;
            idx       <= idx_next;
            sw_onehot <= onehot_next;
            sw_valid  <= valid_next;
            exact     <= exact_next;
            range_err <= err_next;
        end
    end

endmodule

// File: tb/tb_angle_to_sw.sv
// tb/tb_angle_to_sw.sv - randomized and directed self-checking bench for angle_to_sw
module tb_angle_to_sw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  angle_in = '0;
    logic        angle_valid = 1'b0;
    logic        angle_ready;
    logic [15:0] sw_onehot;
    logic        sw_valid;
    logic        exact;
    logic        range_err;

    int n_cmp = 0;
    int n_bad = 0;

    angle_to_sw dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .angle_in    (angle_in),
        .angle_valid (angle_valid),
        .angle_ready (angle_ready),
        .sw_onehot   (sw_onehot),
        .sw_valid    (sw_valid),
        .exact       (exact),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: position = floor(angle/24) (optionally rounded half up), result after q+1 edges
    task automatic model(input int a, output int lat, output logic [15:0] oh,
                         output logic ex, output logic err);
        int q, r, pos;
        if (a > 360) begin
            lat = 0; oh = 16'h0; ex = 1'b0; err = 1'b1;
        end else begin
            q = a / 24;
            r = a % 24;
            pos = q;
`ifdef ANGLE_ROUND_EN
            if (r >= 12) pos = pos + 1;
`endif
            lat = q + 1;
            oh  = 16'h1 << pos;
            ex  = (r == 0);
            err = 1'b0;
        end
    endtask

    // Waits at negedges for sw_valid; lat counts edges after the accepting edge (99 on timeout)
    task automatic wait_result(output int lat);
        lat = 99;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sw_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic send_and_check(input int a, input string tag);
        int          lat, exp_lat, n;
        logic [15:0] exp_oh;
        logic        exp_ex, exp_err;
        model(a, exp_lat, exp_oh, exp_ex, exp_err);
        n = 0;
        while (!angle_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready_in"}, angle_ready, 1);
        angle_in    = 9'(a);
        angle_valid = 1'b1;
        @(posedge clk);
        #1 angle_valid = 1'b0;
        wait_result(lat);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_onehot"}, sw_onehot, exp_oh);
        check_eq({tag, "_exact"}, exact, exp_ex);
        check_eq({tag, "_range_err"}, range_err, exp_err);
        check_eq({tag, "_ready_out"}, angle_ready, 1);
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, sw_valid, 0);
        check_eq({tag, "_hold"}, sw_onehot, exp_oh);
    endtask

    initial begin
        int          lat, pulses;
        int          dir_list[11] = '{0, 96, 360, 36, 35, 400, 24, 361, 23, 359, 511};
        int          a;

        #12;
        check_eq("rst_onehot", sw_onehot, 16'h0001);
        check_eq("rst_exact", exact, 1);
        check_eq("rst_range_err", range_err, 0);
        check_eq("rst_valid", sw_valid, 0);
        check_eq("rst_ready", angle_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir_list[i]) send_and_check(dir_list[i], $sformatf("dir%0d_a%0d", i, dir_list[i]));

        // Valid held with a second angle during the division: only the ready cycle accepts it
        angle_in    = 9'd240;
        angle_valid = 1'b1;
        @(posedge clk);
        #1 angle_in = 9'd48;
        wait_result(lat);
        check_eq("hold240_latency", lat, 11);
        check_eq("hold240_onehot", sw_onehot, 16'h0400);
        check_eq("hold240_ready", angle_ready, 1);
        @(posedge clk);
        #1 angle_valid = 1'b0;
        wait_result(lat);
        check_eq("b2b48_latency", lat, 3);
        check_eq("b2b48_onehot", sw_onehot, 16'h0004);
        check_eq("b2b48_exact", exact, 1);
        @(negedge clk);

        // Reset in the middle of a conversion abandons it
        angle_in    = 9'd300;
        angle_valid = 1'b1;
        @(posedge clk);
        #1 angle_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_onehot", sw_onehot, 16'h0001);
        check_eq("midrst_exact", exact, 1);
        check_eq("midrst_range_err", range_err, 0);
        check_eq("midrst_valid", sw_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sw_valid) pulses++;
        end
        check_eq("midrst_no_result", pulses, 0);
        check_eq("midrst_ready", angle_ready, 1);
        check_eq("midrst_onehot_after", sw_onehot, 16'h0001);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 360));
            send_and_check(a, $sformatf("rnd%0d_a%0d", i, a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
